// File: rtl/monkey_action_ctrl_pkg.sv
// Shared widths, default parameters, state encoding and command payload for the monkey action controller.
// INVULN_FRAMES_DEF exists only when MONKEY_INVULN_EN is defined.
package monkey_ctrl_pkg;

  localparam int unsigned TIMER_W = 7;
  localparam int unsigned LIVES_W = 2;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned Y_W     = 11;

  localparam int unsigned LIVES_INIT_DEF           = 3;
  localparam int unsigned DEATH_FRAMES_DEF         = 60;
  localparam int unsigned RESPAWN_FRAMES_DEF       = 30;
  localparam int unsigned JUMP_COOLDOWN_FRAMES_DEF = 8;
  localparam int unsigned FALL_LIMIT_Y_DEF         = 440;
`ifdef MONKEY_INVULN_EN
  localparam int unsigned INVULN_FRAMES_DEF        = 90;
`endif

  typedef enum logic [STATE_W-1:0] {
    GROUND  = 3'd0,
    AIR     = 3'd1,
    CLIMB   = 3'd2,
    DYING   = 3'd3,
    RESPAWN = 3'd4,
    OVER    = 3'd5
  } monkey_state_t;

  // Gated commands handed to the movement datapath
  typedef struct packed {
    logic moveLeft;
    logic moveRight;
    logic climbUp;
    logic climbDown;
    logic jumpReq;
  } monkey_cmd_t;

endpackage

// File: rtl/monkey_action_ctrl_if.sv
// Key/status inputs and gated command outputs exchanged between the monkey controller and its neighbours.
// master = controller side, slave = keyboard decoder / movement datapath side.
interface monkey_action_ctrl_if;
  import monkey_ctrl_pkg::*;

  logic                       leftPressed;
  logic                       rightPressed;
  logic                       upPressed;
  logic                       downPressed;
  logic                       onRope;
  logic                       footing;
  logic                       enemyHit;
  logic signed [Y_W-1:0]      topLeftY;

  logic                       moveLeft;
  logic                       moveRight;
  logic                       climbUp;
  logic                       climbDown;
  logic                       jumpReq;
  logic                       freeze;
  logic                       moverResetN;
  logic [LIVES_W-1:0]         lives;
  logic                       gameOver;
  logic [STATE_W-1:0]         stateCode;
  logic                       invuln;

  modport master (
    input  leftPressed, rightPressed, upPressed, downPressed,
    input  onRope, footing, enemyHit, topLeftY,
    output moveLeft, moveRight, climbUp, climbDown, jumpReq,
    output freeze, moverResetN, lives, gameOver, stateCode, invuln
  );

  modport slave (
    output leftPressed, rightPressed, upPressed, downPressed,
    output onRope, footing, enemyHit, topLeftY,
    input  moveLeft, moveRight, climbUp, climbDown, jumpReq,
    input  freeze, moverResetN, lives, gameOver, stateCode, invuln
  );

endinterface

// File: rtl/monkey_action_ctrl_frame_timer.sv
// Loadable frame down-counter: load wins over tick, saturates at zero, registered zero flag.
module frame_timer
  import monkey_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               resetN,
  input  logic               tick,
  input  logic               load,
  input  logic [TIMER_W-1:0] loadValue,
  output logic               isZero
);

  logic [TIMER_W-1:0] count;
  logic [TIMER_W-1:0] countNext_c;

  always_comb begin
    countNext_c = count;
    if (load) begin
      countNext_c = loadValue;
    end else if (tick && (count != '0)) begin
      countNext_c = count - TIMER_W'(1);
    end
  end

  // Zero flag is registered alongside the count so it never glitches downstream
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count  <= '0;
      isZero <= 1'b1;
    end else begin
      count  <= countNext_c;
      isZero <= (countNext_c == '0);
    end
  end

endmodule

// File: rtl/monkey_action_ctrl.sv
// Per-player action sequencer: gates key levels into movement commands and runs alive/dying/respawn/over.
// Define MONKEY_INVULN_EN to add a post-respawn grace period during which enemy hits are ignored.
module monkey_action_ctrl
  import monkey_ctrl_pkg::*;
#(
  parameter int unsigned LIVES_INIT           = LIVES_INIT_DEF,
  parameter int unsigned DEATH_FRAMES         = DEATH_FRAMES_DEF,
  parameter int unsigned RESPAWN_FRAMES       = RESPAWN_FRAMES_DEF,
  parameter int unsigned JUMP_COOLDOWN_FRAMES = JUMP_COOLDOWN_FRAMES_DEF,
  parameter int unsigned FALL_LIMIT_Y         = FALL_LIMIT_Y_DEF
`ifdef MONKEY_INVULN_EN
  ,
  parameter int unsigned INVULN_FRAMES        = INVULN_FRAMES_DEF
`endif
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 startOfFrame,
  monkey_action_ctrl_if.master bus
);

  localparam logic signed [Y_W-1:0] FALL_Y = Y_W'(FALL_LIMIT_Y);

  monkey_state_t      state;
  monkey_state_t      nextState_c;
  monkey_cmd_t        cmd;
  monkey_cmd_t        cmdNext_c;
  logic               upPrev;
  logic               stateTimerZero;
  logic               cooldownZero;
  logic               invulnOn;
  logic               timerLoad_c;
  logic [TIMER_W-1:0] timerLoadValue_c;
  logic               cooldownLoad_c;
  logic               livesDec_c;
  logic               jumpFire_c;
  logic               activeNext_c;
  logic               jumpEdge_c;
  logic               deathTrig_c;
  logic               freeze;
  logic               moverRstN;
  logic               gameOver;
  logic [LIVES_W-1:0] lives;

  assign jumpEdge_c  = bus.upPressed && !upPrev;
  assign deathTrig_c = (bus.enemyHit && !invulnOn) || (bus.topLeftY >= FALL_Y);

  frame_timer uStateTimer (
    .clk       (clk),
    .resetN    (resetN),
    .tick      (startOfFrame),
    .load      (timerLoad_c),
    .loadValue (timerLoadValue_c),
    .isZero    (stateTimerZero)
  );

  frame_timer uCooldownTimer (
    .clk       (clk),
    .resetN    (resetN),
    .tick      (startOfFrame),
    .load      (cooldownLoad_c),
    .loadValue (TIMER_W'(JUMP_COOLDOWN_FRAMES)),
    .isZero    (cooldownZero)
  );

`ifdef MONKEY_INVULN_EN
  logic invulnLoad_c;
  logic invulnZero;

  // Grace period starts on the same edge that releases the monkey back to GROUND
  assign invulnLoad_c = (state == RESPAWN) && stateTimerZero;

  frame_timer uInvulnTimer (
    .clk       (clk),
    .resetN    (resetN),
    .tick      (startOfFrame),
    .load      (invulnLoad_c),
    .loadValue (TIMER_W'(INVULN_FRAMES)),
    .isZero    (invulnZero)
  );

  assign invulnOn = !invulnZero;
`else
  assign invulnOn = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= GROUND;
    end else begin
      state <= nextState_c;
    end
  end

  // Next state, timer loads and next values of the registered outputs
  always_comb begin
    nextState_c      = state;
    timerLoad_c      = 1'b0;
    timerLoadValue_c = '0;
    cooldownLoad_c   = 1'b0;
    livesDec_c       = 1'b0;
    jumpFire_c       = 1'b0;

    case (state)
      GROUND: begin
        if (deathTrig_c) begin
          nextState_c      = DYING;
          timerLoad_c      = 1'b1;
          timerLoadValue_c = TIMER_W'(DEATH_FRAMES);
        end else if (bus.onRope && (bus.upPressed || bus.downPressed)) begin
          nextState_c = CLIMB;
        end else if (jumpEdge_c && !bus.onRope && cooldownZero) begin
          nextState_c = AIR;
          jumpFire_c  = 1'b1;
        end else if (!bus.footing) begin
          nextState_c = AIR;
        end
      end
      AIR: begin
        if (deathTrig_c) begin
          nextState_c      = DYING;
          timerLoad_c      = 1'b1;
          timerLoadValue_c = TIMER_W'(DEATH_FRAMES);
        end else if (bus.footing) begin
          nextState_c    = GROUND;
          cooldownLoad_c = 1'b1;
        end
      end
      CLIMB: begin
        if (deathTrig_c) begin
          nextState_c      = DYING;
          timerLoad_c      = 1'b1;
          timerLoadValue_c = TIMER_W'(DEATH_FRAMES);
        end else if (!bus.onRope) begin
          nextState_c = AIR;
        end
      end
      DYING: begin
        if (stateTimerZero) begin
          livesDec_c = 1'b1;
          if (lives <= LIVES_W'(1)) begin
            nextState_c = OVER;
          end else begin
            nextState_c      = RESPAWN;
            timerLoad_c      = 1'b1;
            timerLoadValue_c = TIMER_W'(RESPAWN_FRAMES);
          end
        end
      end
      RESPAWN: begin
        if (stateTimerZero) begin
          nextState_c = GROUND;
        end
      end
      OVER: begin
        nextState_c = OVER;
      end
      default: begin
        nextState_c = GROUND;
      end
    endcase

    // Commands follow the state the monkey is entering, so a death silences them immediately
    activeNext_c        = (nextState_c == GROUND) || (nextState_c == AIR) || (nextState_c == CLIMB);
    cmdNext_c.moveLeft  = activeNext_c && bus.leftPressed && !bus.rightPressed;
    cmdNext_c.moveRight = activeNext_c && bus.rightPressed && !bus.leftPressed;
    cmdNext_c.climbUp   = (nextState_c == CLIMB) && bus.upPressed && !bus.downPressed;
    cmdNext_c.climbDown = (nextState_c == CLIMB) && bus.downPressed && !bus.upPressed;
    cmdNext_c.jumpReq   = jumpFire_c;
  end

  // Registered outputs, edge history and lives
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cmd       <= '0;
      upPrev    <= 1'b0;
      freeze    <= 1'b0;
      moverRstN <= 1'b1;
      gameOver  <= 1'b0;
      lives     <= LIVES_W'(LIVES_INIT);
    end else begin
      cmd       <= cmdNext_c;
      upPrev    <= bus.upPressed;
      freeze    <= !activeNext_c;
      moverRstN <= !((state == DYING) && (nextState_c == RESPAWN));
      gameOver  <= (nextState_c == OVER);
      if (livesDec_c && (lives != '0)) begin
        lives <= lives - LIVES_W'(1);
      end
    end
  end

  assign bus.moveLeft    = cmd.moveLeft;
  assign bus.moveRight   = cmd.moveRight;
  assign bus.climbUp     = cmd.climbUp;
  assign bus.climbDown   = cmd.climbDown;
  assign bus.jumpReq     = cmd.jumpReq;
  assign bus.freeze      = freeze;
  assign bus.moverResetN = moverRstN;
  assign bus.gameOver    = gameOver;
  assign bus.lives       = lives;
  assign bus.stateCode   = state;
  assign bus.invuln      = invulnOn;

endmodule

// File: doc/monkey_action_ctrl.md
Name: monkey_action_ctrl

Overview:
- Per-player sequencer that sits between the keyboard decoder and the monkey movement datapath.
- Turns raw key levels plus footing/collision status into gated movement commands: left/right, climb, and a one-shot jump request.
- Runs the life cycle: alive, dying, respawn, game over. Drives the movement block's local reset and the lives count shown on the HUD.

Parameters:
- LIVES_INIT, 3: lives loaded at reset.
- DEATH_FRAMES, 60: frames spent in DYING.
- RESPAWN_FRAMES, 30: frames spent in RESPAWN.
- JUMP_COOLDOWN_FRAMES, 8: frames after landing before the next jump is accepted.
- FALL_LIMIT_Y, 440: topLeftY at or above this value counts as a death.
- INVULN_FRAMES, 90: grace period after respawn (optional feature only).

Ports:
- clk, in, 1: system clock.
- resetN, in, 1: asynchronous active-low reset.
- startOfFrame, in, 1: one-clk pulse per frame; all timers count on it.
- leftPressed / rightPressed / upPressed / downPressed, in, 1 each: raw key levels.
- onRope, in, 1: monkey overlaps a rope.
- footing, in, 1: monkey stands on a block or rope.
- enemyHit, in, 1: monkey collided with a hazard.
- topLeftY, in, 11 signed: monkey vertical position.
- moveLeft / moveRight, out, 1: gated horizontal commands to the datapath.
- climbUp / climbDown, out, 1: gated rope commands.
- jumpReq, out, 1: one-clk jump pulse.
- freeze, out, 1: datapath must hold position.
- moverResetN, out, 1: active-low local reset to the movement block.
- lives, out, 2: remaining lives.
- gameOver, out, 1: level output.
- stateCode, out, 3: current state, for debug and HUD.

Behaviour:
- Reset (async, resetN=0):
  - state=GROUND, lives=LIVES_INIT, frame timer=0, cooldown=0.
  - All command outputs 0, freeze=0, moverResetN=1, gameOver=0, stateCode=0.
- All outputs are registered, so they change 1 clk after their cause.
- States and codes: GROUND=0, AIR=1, CLIMB=2, DYING=3, RESPAWN=4, OVER=5.
- GROUND:
  - moveLeft=leftPressed and moveRight=rightPressed, except both are 0 when both keys are pressed.
  - A rising edge of upPressed with onRope=0 and cooldown=0 gives jumpReq=1 for exactly 1 clk, then next state AIR.
  - upPressed or downPressed with onRope=1 goes to CLIMB.
  - footing=0 goes to AIR.
- AIR:
  - Left/right are passed through; climb and jump outputs are 0.
  - footing=1 goes to GROUND and loads cooldown=JUMP_COOLDOWN_FRAMES.
- CLIMB:
  - climbUp=upPressed and climbDown=downPressed, with the same mutual exclusion as left/right. Left/right are passed through.
  - onRope=0 goes to AIR.
- Death trigger: enemyHit=1, or topLeftY>=FALL_LIMIT_Y, while in GROUND, AIR or CLIMB. This goes to DYING and loads the timer with DEATH_FRAMES.
- If a death trigger and a jump edge happen in the same clk, death wins and jumpReq stays 0.
- DYING:
  - freeze=1 and all commands are 0.
  - The timer decrements on each startOfFrame. When it reaches 0: lives decrements; if lives was 1 go to OVER, otherwise go to RESPAWN with timer=RESPAWN_FRAMES.
- RESPAWN:
  - moverResetN=0 for the first clk only, then 1. freeze=1.
  - Timer expiry goes to GROUND.
- OVER:
  - gameOver=1 and freeze=1. The block stays here until resetN.
- Cooldown decrements on startOfFrame and saturates at 0.
- Timers are 7 bits wide; parameters greater than 127 are illegal.
- Further death triggers are ignored in DYING, RESPAWN and OVER.
- lives never goes below 0.

Optional Feature:
- Macro: MONKEY_INVULN_EN.
- Defined:
  - Leaving RESPAWN loads an invulnerability counter with INVULN_FRAMES; it decrements on startOfFrame.
  - While the counter is nonzero, enemyHit is ignored. A fall past FALL_LIMIT_Y still kills.
  - stateCode bit pattern is unchanged. An extra output invuln (1 bit) reflects counter≠0.
- Undefined: the counter and its logic are absent, and invuln is tied to 0.

Decomposition:
- Package monkey_ctrl_pkg holds:
  - the state enum monkey_state_t (3-bit, codes above);
  - the default constants for the lives, frame-timer and cooldown parameters.
- One sub-module, frame_timer: a loadable down-counter clocked by clk that decrements on startOfFrame and flags zero. It is instanced for the state timer, the cooldown and (with the optional feature) invulnerability.

Test Plan:
- Jump: reset, footing=1, onRope=0, pulse upPressed high at clk 10 → jumpReq=1 at clk 11 only, stateCode=1. Holding upPressed gives no second pulse.
- Cooldown: land (footing=1), re-press up after 3 frames → no jumpReq. Press again after 8 frames → jumpReq pulse.
- Death and respawn: enemyHit at frame 0 →
  - stateCode=3 and freeze=1 next clk;
  - after 60 startOfFrame pulses, lives 3→2 and stateCode=4, with moverResetN=0 for 1 clk;
  - after 30 more frames, stateCode=0.
- Game over: three deaths via topLeftY=450 → lives=0, gameOver=1, stateCode=5. The state holds with all keys pressed until resetN.
- Climb: onRope=1, up and down held together → climbUp=0 and climbDown=0. Release down → climbUp=1. onRope drops → stateCode=1.
- Invulnerability (MONKEY_INVULN_EN defined): enemyHit 10 frames after respawn → no state change. Hit at frame 91 → DYING.
